divide_seq: RTL and testbench

Parametrised sequential restoring divider: the next generation of the team's 32-bit iterative divide unit. It adds a generic operand width, a start/valid handshake, an asynchronous reset, and explicit divide-by-zero reporting. It sits beside the ALU in the execute stage and is shared by signed and unsigned divide/remainder instructions. It produces one quotient bit per clock.

---
 rtl/divide_seq.sv | 139 +++++++++++++
 tb/tb_divide_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// Sequential restoring divider, one quotient bit per clock, signed/unsigned, start/valid handshake.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration and finishes in one step.
module divide_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;       // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted, trial;
    logic             dvd_neg, dvs_neg, dvs_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        valid_d = 1'b0;

        shifted  = {rem_q, dq_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        dvd_neg  = sign & dividend[WIDTH-1];
        dvs_neg  = sign & divisor[WIDTH-1];
        dvs_zero = (divisor == '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // With a zero divisor the raw dividend is kept so the iteration
                    // leaves it untouched in the partial remainder.
                    dq_d    = (dvd_neg && !dvs_zero) ? -dividend : dividend;
                    dvs_d   = dvs_neg ? -divisor : divisor;
                    rem_d   = '0;
                    negq_d  = dvd_neg ^ dvs_neg;
                    negr_d  = dvd_neg;
                    zero_d  = dvs_zero;
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (dvs_zero) state_d = FIX;
`endif
                end
            end
            CALC: begin
                dq_d  = {dq_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                valid_d = 1'b1;
                dbz_d   = zero_q;
                if (zero_q) begin
                    quo_d  = '1;
`ifdef DIV_ZERO_FAST_EN
                    remo_d = dq_q;
`else
                    remo_d = rem_q;
`endif
                end else begin
                    quo_d  = negq_q ? -dq_q : dq_q;
                    remo_d = negr_q ? -rem_q : rem_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign valid       = valid_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_seq.sv
// Randomized and directed bench for divide_seq at WIDTH=32 and WIDTH=8 against an arithmetic reference.
module tb_divide_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [63:0] dvd = '0;
    logic [63:0] dvs = '0;
    int          sel_w = 32;

    logic        st32, st8;
    logic        rdy32, vld32, dbz32, rdy8, vld8, dbz8;
    logic [31:0] q32, r32;
    logic [7:0]  q8, r8;
    logic        rdy_m, vld_m, dbz_m;
    logic [63:0] q_m, r_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign st32  = start && (sel_w == 32);
    assign st8   = start && (sel_w == 8);
    assign rdy_m = (sel_w == 8) ? rdy8 : rdy32;
    assign vld_m = (sel_w == 8) ? vld8 : vld32;
    assign dbz_m = (sel_w == 8) ? dbz8 : dbz32;
    assign q_m   = (sel_w == 8) ? {56'b0, q8} : {32'b0, q32};
    assign r_m   = (sel_w == 8) ? {56'b0, r8} : {32'b0, r32};

    divide_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .sign(sgn),
        .dividend(dvd[31:0]), .divisor(dvs[31:0]),
        .ready(rdy32), .valid(vld32), .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    divide_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .sign(sgn),
        .dividend(dvd[7:0]), .divisor(dvs[7:0]),
        .ready(rdy8), .valid(vld8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (w=%0d): got %0h expected %0h", tag, sel_w, got, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation toward zero.
    function automatic void ref_div(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic s, output logic [63:0] q, output logic [63:0] r,
                                    output logic z);
        logic [63:0] m;
        logic [63:0] a, b;
        longint sa, sb;
        m = (64'd1 << w) - 64'd1;
        a = a_in & m;
        b = b_in & m;
        z = (b == 0);
        if (z) begin
            q = m;
            r = a;
        end else if (s) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q  = 64'(sa / sb) & m;
            r  = 64'(sa % sb) & m;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_latency(input logic z);
        int lat;
        lat = sel_w + 1;
`ifdef DIV_ZERO_FAST_EN
        if (z) lat = 1;
`endif
        return lat;
    endfunction

    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic s, input string tag);
        @(negedge clk);
        chk({tag, ":ready_idle"}, 64'(rdy_m), 64'd1);
        dvd = a; dvs = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dvd = {$urandom, $urandom}; dvs = {$urandom, $urandom}; sgn = 1'($urandom);
        chk({tag, ":ready_busy"}, 64'(rdy_m), 64'd0);
    endtask

    // Returns with time sitting just after the edge that raised valid.
    task automatic wait_result(input logic [63:0] a, input logic [63:0] b, input logic s,
                               input int n0, input string tag);
        logic [63:0] eq, er;
        logic        ez;
        int          n;
        bit          got;
        ref_div(sel_w, a, b, s, eq, er, ez);
        n = n0;
        got = 0;
        while (n < 300 && !got) begin
            @(posedge clk); n++; #1;
            if (vld_m) got = 1;
        end
        chk({tag, ":latency"}, 64'(n), 64'(exp_latency(ez)));
        chk({tag, ":quotient"}, q_m, eq);
        chk({tag, ":remainder"}, r_m, er);
        chk({tag, ":dbz"}, 64'(dbz_m), 64'(ez));
        chk({tag, ":ready_valid"}, 64'(rdy_m), 64'd1);
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s, input string tag);
        launch(a, b, s, tag);
        wait_result(a, b, s, 0, tag);
        @(posedge clk); #1;
        chk({tag, ":valid_pulse"}, 64'(vld_m), 64'd0);
    endtask

    task automatic edge_suite(input string tag);
        logic [63:0] m, mn;
        logic [63:0] a, b;
        int pulses;
        m  = (64'd1 << sel_w) - 64'd1;
        mn = 64'd1 << (sel_w - 1);
        do_op(64'd100, 64'd7, 1'b0, {tag, ".u100_7"});
        do_op((-64'd100) & m, 64'd7, 1'b1, {tag, ".sm100_7"});
        do_op(64'd100, (-64'd7) & m, 1'b1, {tag, ".s100_m7"});
        do_op((-64'd128) & m, 64'd3, 1'b1, {tag, ".sm128_3"});
        do_op(64'h12345678 & m, 64'd0, 1'b0, {tag, ".dbz_u"});
        do_op(mn | 64'd5, 64'd0, 1'b1, {tag, ".dbz_s"});
        do_op(mn, m, 1'b1, {tag, ".ovf"});
        do_op(m, 64'd1, 1'b0, {tag, ".max_1"});
        do_op(m, m, 1'b0, {tag, ".max_max"});
        do_op(64'd3, 64'd9, 1'b0, {tag, ".small"});

        // A start pulse while busy must be dropped, not queued.
        launch(64'd200, 64'd9, 1'b0, {tag, ".busy"});
        repeat (4) @(posedge clk);
        dvd = 64'd50; dvs = 64'd5; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(64'd200, 64'd9, 1'b0, 5, {tag, ".busy"});
        pulses = 0;
        for (int i = 0; i < sel_w + 4; i++) begin
            @(posedge clk); #1;
            if (vld_m) pulses++;
            if (!rdy_m) pulses += 100;
        end
        chk({tag, ".busy:ignored"}, 64'(pulses), 64'd0);

        // Back-to-back: second request presented during the valid cycle.
        launch(64'd77, 64'd4, 1'b0, {tag, ".b2b_a"});
        wait_result(64'd77, 64'd4, 1'b0, 0, {tag, ".b2b_a"});
        a = (-64'd99) & m; b = 64'd10;
        dvd = a; dvs = b; sgn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".b2b:ready_busy"}, 64'(rdy_m), 64'd0);
        wait_result(a, b, 1'b1, 0, {tag, ".b2b_b"});

        // Reset in the middle of CALC discards the operation.
        launch(64'd1000, 64'd3, 1'b0, {tag, ".rst"});
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk({tag, ".rst:ready"}, 64'(rdy_m), 64'd1);
        chk({tag, ".rst:valid"}, 64'(vld_m), 64'd0);
        chk({tag, ".rst:quotient"}, q_m, 64'd0);
        chk({tag, ".rst:remainder"}, r_m, 64'd0);
        chk({tag, ".rst:dbz"}, 64'(dbz_m), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < sel_w + 6; i++) begin
            @(posedge clk); #1;
            if (vld_m) pulses++;
        end
        chk({tag, ".rst:no_valid"}, 64'(pulses), 64'd0);
        do_op(64'd1000, 64'd3, 1'b0, {tag, ".post_rst"});
    endtask

    task automatic random_suite(input int cnt, input string tag);
        logic [63:0] a, b;
        logic        s;
        for (int i = 0; i < cnt; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       b = 64'd0;
                1, 2, 3: b = 64'($urandom_range(1, 20));
                4:       b = -64'($urandom_range(1, 20));
                default: b = {$urandom, $urandom};
            endcase
            s = 1'($urandom);
            do_op(a, b, s, tag);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sel_w = 32;
        chk("reset:ready", 64'(rdy_m), 64'd1);
        chk("reset:valid", 64'(vld_m), 64'd0);
        chk("reset:quotient", q_m, 64'd0);
        chk("reset:remainder", r_m, 64'd0);
        chk("reset:dbz", 64'(dbz_m), 64'd0);
        sel_w = 8;
        chk("reset:ready", 64'(rdy_m), 64'd1);
        chk("reset:quotient", q_m, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        sel_w = 32;
        edge_suite("w32");
        random_suite(40, "w32.rand");
        sel_w = 8;
        edge_suite("w8");
        random_suite(60, "w8.rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
